bist_controller: RTL and testbench

- Sequences one BIST session around the 9-bit maximal-length pattern generator: holds the generator in reset, releases it for exactly NUM_PATTERNS cycles, and compacts the circuit-under-test response into an internal MISR.
- At the end of the session it compares the signature against a golden value and reports pass/fail.
- Sits between the test access logic (start/abort) and the TPG + CUT pair; the generator's reset input is driven only by this block.

---
 rtl/bist_controller.sv | 141 ++++++++++++++
 tb/tb_bist_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// BIST session sequencer: holds the pattern generator in reset, runs it for NUM_PATTERNS
// cycles while compacting the CUT response into a MISR, then checks the signature.
module bist_controller #(
    parameter int               WIDTH        = 9,
    parameter int               NUM_PATTERNS = 511,
    parameter int               MISR_TAP     = 5,
    parameter logic [WIDTH-1:0] GOLDEN_SIG   = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cut_response,
    output logic             tpg_reset,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sig_r;
    logic             pass_r;
    logic             tpg_reset_r;
    logic             test_mode_r;
    logic             busy_r;
    logic             done_r;

    // One MISR step: shift with two-tap feedback, then fold in the response.
    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] resp);
        logic fb;
        fb = sig[WIDTH-1] ^ sig[MISR_TAP];
        return {sig[WIDTH-2:0], fb} ^ resp;
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort only matters while a session is in flight.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_INIT;
                else       state_next_s = ST_IDLE;
            end
            ST_INIT: begin
                if (abort) state_next_s = ST_IDLE;
                else       state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                  state_next_s = ST_IDLE;
                else if (cnt_r == LAST_CNT) state_next_s = ST_COMPARE;
                else                        state_next_s = ST_RUN;
            end
            ST_COMPARE: begin
                if (abort) state_next_s = ST_IDLE;
                else       state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_next_s = ST_INIT;
                else       state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Counter, MISR and verdict; the MISR keeps its value when a session is aborted.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            sig_r  <= {WIDTH{1'b0}};
            pass_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    sig_r  <= {WIDTH{1'b0}};
                    pass_r <= 1'b0;
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    sig_r <= misr_next(sig_r, cut_response);
                end
                ST_COMPARE: begin
                    pass_r <= (sig_r == GOLDEN_SIG);
                end
                default: begin
                    cnt_r  <= cnt_r;
                    sig_r  <= sig_r;
                    pass_r <= pass_r;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they land in flops aligned with state_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            tpg_reset_r <= 1'b1;
            test_mode_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            tpg_reset_r <= (state_next_s != ST_RUN);
            test_mode_r <= (state_next_s == ST_INIT) || (state_next_s == ST_RUN);
            busy_r      <= (state_next_s == ST_INIT) || (state_next_s == ST_RUN) ||
                           (state_next_s == ST_COMPARE);
            done_r      <= (state_next_s == ST_DONE);
        end
    end

    assign tpg_reset = tpg_reset_r;
    assign test_mode = test_mode_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig_r;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: a cycle table on short sessions, then random
// sessions checked against an arithmetic MISR model, plus a full 511-pattern session.
module tb_bist_controller;

    localparam int NP_A = 3;
    localparam int NP_C = 511;
    localparam int S_I = 0, S_N = 1, S_R = 2, S_C = 3, S_D = 4;

    logic       clock = 1'b0;
    logic       reset, start, abort;
    logic [8:0] resp;
    logic       tpg_a, tm_a, busy_a, done_a, pass_a;
    logic [8:0] sig_a;
    logic       tpg_b, tm_b, busy_b, done_b, pass_b;
    logic [8:0] sig_b;
    logic       reset_c, start_c, abort_c;
    logic [8:0] resp_c;
    logic       tpg_c, tm_c, busy_c, done_c, pass_c;
    logic [8:0] sig_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    bist_controller #(.WIDTH(9), .NUM_PATTERNS(NP_A), .MISR_TAP(5), .GOLDEN_SIG(9'h007)) dut_a (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .cut_response(resp),
        .tpg_reset(tpg_a), .test_mode(tm_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a));

    bist_controller #(.WIDTH(9), .NUM_PATTERNS(NP_A), .MISR_TAP(5), .GOLDEN_SIG(9'h000)) dut_b (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .cut_response(resp),
        .tpg_reset(tpg_b), .test_mode(tm_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b));

    bist_controller #(.WIDTH(9), .NUM_PATTERNS(NP_C), .MISR_TAP(5), .GOLDEN_SIG(9'h000)) dut_c (
        .clock(clock), .reset(reset_c), .start(start_c), .abort(abort_c), .cut_response(resp_c),
        .tpg_reset(tpg_c), .test_mode(tm_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .signature(sig_c));

    typedef struct packed {
        logic       rst, st, ab;
        logic [8:0] resp;
        logic       tpg, tm, busy, done;
        logic       chk_pass, pass_a, pass_b;
        logic       chk_sig;
        logic [8:0] sig;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(logic rst, logic st, logic ab, logic [8:0] r, int s,
                                logic cp, logic pa, logic pb, logic cs, logic [8:0] sg);
        vec_t v;
        v.rst = rst; v.st = st; v.ab = ab; v.resp = r;
        v.tpg  = (s != S_R);
        v.tm   = (s == S_N) || (s == S_R);
        v.busy = (s == S_N) || (s == S_R) || (s == S_C);
        v.done = (s == S_D);
        v.chk_pass = cp; v.pass_a = pa; v.pass_b = pb;
        v.chk_sig = cs; v.sig = sg;
        return v;
    endfunction

    // Reference MISR step: shift left, feedback = bit8 xor bit5, xor in the response.
    function automatic int unsigned misr_step(int unsigned s, int unsigned r);
        return ((((s << 1) & 32'h1FF) | (((s >> 8) ^ (s >> 5)) & 32'h1)) ^ r) & 32'h1FF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Random session on dut_a/dut_b: start pulse, then random responses and start noise.
    task automatic session_ab();
        int unsigned m;
        start = 1'b1; abort = 1'b0; resp = 9'($urandom_range(0, 511));
        tick();
        check("rnd_ab_init_busy", busy_a, 1'b1);
        m = 0;
        for (int e = 1; e <= NP_A + 2; e++) begin
            start = 1'($urandom_range(0, 1));
            resp  = 9'($urandom_range(0, 511));
            tick();
            if (e >= 2 && e <= NP_A + 1) m = misr_step(m, resp);
            check("rnd_ab_sig_a", sig_a, m);
            check("rnd_ab_sig_b", sig_b, m);
            check("rnd_ab_done", done_a, (e == NP_A + 2));
            check("rnd_ab_tpg", tpg_a, !(e >= 1 && e <= NP_A));
        end
        check("rnd_ab_pass_a", pass_a, (m == 32'h7));
        check("rnd_ab_pass_b", pass_b, (m == 32'h0));
    endtask

    // Full-length session on dut_c; zero_resp selects the all-zero response case.
    task automatic session_c(input logic zero_resp);
        int unsigned m;
        int busy_cnt, tpg_low;
        start_c = 1'b1; abort_c = 1'b0; resp_c = 9'h000;
        tick();
        busy_cnt = int'(busy_c);
        tpg_low  = int'(!tpg_c);
        m = 0;
        for (int e = 1; e <= NP_C + 2; e++) begin
            start_c = zero_resp ? 1'b0 : 1'($urandom_range(0, 1));
            resp_c  = zero_resp ? 9'h000 : 9'($urandom_range(0, 511));
            tick();
            if (e >= 2 && e <= NP_C + 1) m = misr_step(m, resp_c);
            busy_cnt += int'(busy_c);
            tpg_low  += int'(!tpg_c);
            check("c_sig", sig_c, m);
            check("c_done", done_c, (e == NP_C + 2));
        end
        check("c_busy_cycles", busy_cnt, NP_C + 2);
        check("c_tpg_low_cycles", tpg_low, NP_C);
        check("c_pass", pass_c, (m == 32'h0));
        start_c = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; resp = 9'h000;
        reset_c = 1'b1; start_c = 1'b0; abort_c = 1'b0; resp_c = 9'h000;

        //          rst   st    ab    resp    state cp    pa    pb    cs    sig
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 9'h001, S_I, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 9'h001, S_N, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h003);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 9'h001, S_C, 1'b1, 1'b0, 1'b0, 1'b1, 9'h007);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 9'h001, S_D, 1'b1, 1'b1, 1'b0, 1'b1, 9'h007);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 9'h001, S_D, 1'b1, 1'b1, 1'b0, 1'b1, 9'h007);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 9'h001, S_N, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h003);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 9'h001, S_C, 1'b1, 1'b0, 1'b0, 1'b1, 9'h007);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 9'h001, S_D, 1'b1, 1'b1, 1'b0, 1'b1, 9'h007);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 9'h001, S_N, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 9'h001, S_I, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 9'h001, S_I, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 9'h001, S_N, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001);
        tbl[22] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h003);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_C, 1'b1, 1'b0, 1'b0, 1'b1, 9'h007);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_D, 1'b1, 1'b1, 1'b0, 1'b1, 9'h007);
        tbl[25] = mk(1'b0, 1'b1, 1'b1, 9'h001, S_N, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
        tbl[26] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[27] = mk(1'b0, 1'b0, 1'b0, 9'h001, S_R, 1'b1, 1'b0, 1'b0, 1'b1, 9'h001);
        tbl[28] = mk(1'b1, 1'b0, 1'b0, 9'h001, S_I, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[29] = mk(1'b1, 1'b1, 1'b0, 9'h001, S_I, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        tbl[30] = mk(1'b0, 1'b0, 1'b1, 9'h001, S_I, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000);

        for (int i = 0; i < 31; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; abort = tbl[i].ab; resp = tbl[i].resp;
            tick();
            check($sformatf("row%0d_tpg_reset", i), tpg_a, tbl[i].tpg);
            check($sformatf("row%0d_test_mode", i), tm_a, tbl[i].tm);
            check($sformatf("row%0d_busy", i), busy_a, tbl[i].busy);
            check($sformatf("row%0d_done", i), done_a, tbl[i].done);
            check($sformatf("row%0d_done_b", i), done_b, tbl[i].done);
            if (tbl[i].chk_pass) begin
                check($sformatf("row%0d_pass_a", i), pass_a, tbl[i].pass_a);
                check($sformatf("row%0d_pass_b", i), pass_b, tbl[i].pass_b);
            end
            if (tbl[i].chk_sig) begin
                check($sformatf("row%0d_sig_a", i), sig_a, tbl[i].sig);
                check($sformatf("row%0d_sig_b", i), sig_b, tbl[i].sig);
            end
        end

        for (int k = 0; k < 20; k++) session_ab();

        reset_c = 1'b1;
        tick();
        check("c_reset_sig", sig_c, 9'h000);
        check("c_reset_tpg", tpg_c, 1'b1);
        reset_c = 1'b0;
        session_c(1'b1);
        session_c(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
